// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end: pin synchronisers, RX deserialiser, TX serialiser.
// Optional macro SPI_MISO_OE_EN adds o_miso_oe for an external tristate buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module spi_slave_if #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
`ifdef SPI_MISO_OE_EN
    output logic                  o_miso_oe,
`endif
    input  logic [DATA_WIDTH-1:0] i_spi_data_tx,
    output logic [DATA_WIDTH-1:0] o_spi_data_rx,
    output logic                  o_spi_ready,
    output logic                  o_spi_busy
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sclk_q;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sync_ok;
    logic                   rise;
    logic                   fall;
    logic                   miso_trk;
    logic                   miso_idle;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [CW-1:0]          cnt;
    logic                   done;

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    // The cs copy is only trusted once the chain holds real pin samples,
    // otherwise the idle reset value would let us join a running frame.
    assign sync_ok  = fill[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_q;
    assign fall     = ~sclk_s & sclk_q;
    assign miso_trk = i_spi_data_tx[DATA_WIDTH-1];

`ifdef SPI_MISO_OE_EN
    assign miso_idle = miso_trk;
`else
    assign miso_idle = 1'b0;
`endif

    // Pin synchronisers, fill tracker and previous SCLK sample for edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_q    <= sclk_s;
        end
    end

    // Frame FSM with shift registers, bit counter and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= SYNC_WAIT;
            rx_shift      <= '0;
            tx_shift      <= '0;
            cnt           <= '0;
            done          <= 1'b0;
            o_spi_data_rx <= '0;
            o_spi_ready   <= 1'b0;
            o_spi_busy    <= 1'b0;
            o_miso        <= 1'b0;
`ifdef SPI_MISO_OE_EN
            o_miso_oe     <= 1'b0;
`endif
        end else begin
            // A completed word is published one cycle after its last shift.
            done        <= 1'b0;
            o_spi_ready <= done;
            if (done) begin
                o_spi_data_rx <= rx_shift;
            end

            unique case (state)
                SYNC_WAIT: begin
                    cnt    <= '0;
                    o_miso <= miso_idle;
                    if (sync_ok && cs_s) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    cnt    <= '0;
                    o_miso <= miso_idle;
                    if (!cs_s) begin
                        state      <= SHIFT;
                        o_spi_busy <= 1'b1;
                        o_miso     <= miso_trk;
`ifdef SPI_MISO_OE_EN
                        o_miso_oe  <= 1'b1;
`endif
                    end
                end

                SHIFT: begin
                    if (rise) begin
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        if (cnt == LAST) begin
                            cnt  <= '0;
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        if (cnt == '0) begin
                            tx_shift <= i_spi_data_tx;
                            o_miso   <= miso_trk;
                        end
                    end else if (cnt == '0) begin
                        // Between words MISO follows the controller's next MSB.
                        o_miso <= miso_trk;
                    end else if (fall) begin
                        tx_shift <= tx_shift << 1;
                        o_miso   <= tx_shift[DATA_WIDTH-2];
                    end

                    // CS release drops any partial word; a word completing
                    // on this same cycle still reports through done.
                    if (cs_s) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        o_spi_busy <= 1'b0;
                        o_miso     <= miso_idle;
`ifdef SPI_MISO_OE_EN
                        o_miso_oe  <= 1'b0;
`endif
                    end
                end

                default: begin
                    state      <= SYNC_WAIT;
                    cnt        <= '0;
                    o_spi_busy <= 1'b0;
                    o_miso     <= 1'b0;
`ifdef SPI_MISO_OE_EN
                    o_miso_oe  <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Testbench for spi_slave_if: SPI master model at SCLK = clk/10,
// reference expectations built from whole words and frames.
module tb_spi_slave_if;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [DW-1:0] tx = '0;
    logic [DW-1:0] rx;
    logic          ready;
    logic          busy;
`ifdef SPI_MISO_OE_EN
    logic          miso_oe;
`endif

    int checks = 0;
    int errors = 0;

    int            cyc = 0;
    logic [DW-1:0] rdy_q[$];
    int            rdy_cyc = 0;
    int            last_rise_cyc = 0;
    logic [DW-1:0] prev_rx = '0;
    int            bad_change = 0;
    int            busy_low = 0;
    bit            in_frame = 1'b0;

    spi_slave_if #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sclk       (sclk),
        .i_cs_n       (cs_n),
        .i_mosi       (mosi),
        .o_miso       (miso),
`ifdef SPI_MISO_OE_EN
        .o_miso_oe    (miso_oe),
`endif
        .i_spi_data_tx(tx),
        .o_spi_data_rx(rx),
        .o_spi_ready  (ready),
        .o_spi_busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: collects ready pulses, watches rx and busy
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rx = rx;
        end else begin
            if (ready) begin
                rdy_q.push_back(rx);
                rdy_cyc = cyc;
            end
            if (rx !== prev_rx && ready !== 1'b1) bad_change++;
            prev_rx = rx;
            if (in_frame && busy !== 1'b1) busy_low++;
        end
    end

    task automatic half();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        half();
        in_frame = 1'b1;
    endtask

    task automatic cs_high();
        in_frame = 1'b0;
        cs_n = 1'b1;
        half();
        half();
    endtask

    // Master: shifts nbits of d MSB first, samples MISO just before each rise
    task automatic xfer(input logic [DW-1:0] d, input int nbits,
                        output logic [DW-1:0] m);
        m = '0;
        for (int k = 0; k < nbits; k++) begin
            int i;
            i = DW - 1 - k;
            mosi = d[i];
            half();
            m[i] = miso;
            sclk = 1'b1;
            last_rise_cyc = cyc;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx !== '0 || ready !== 1'b0 || busy !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: rx=%h rdy=%b busy=%b miso=%b want 00 0 0 0",
                     rx, ready, busy, miso);
        end
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || miso !== 1'b0 || rdy_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset: busy=%b miso=%b readys=%0d want 0 0 0",
                     busy, miso, rdy_q.size());
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] m;
        rdy_q.delete();
        busy_low = 0;
        tx = 8'h00;
        cs_low();
        xfer(8'hA5, 8, m);
        cs_high();
        checks++;
        if (rdy_q.size() != 1 || rdy_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL basic_rx: readys=%0d first=%h want 1 a5",
                     rdy_q.size(), rdy_q.size() ? rdy_q[0] : 8'h00);
        end
        checks++;
        if (busy_low != 0) begin
            errors++;
            $display("FAIL basic_busy: low_cycles=%0d want 0", busy_low);
        end
        checks++;
        if (rdy_cyc - last_rise_cyc != 1 + SS + 1) begin
            errors++;
            $display("FAIL latency: got %0d want %0d",
                     rdy_cyc - last_rise_cyc, 1 + SS + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_miso();
        logic [DW-1:0] m;
        logic [DW-1:0] d;
        rdy_q.delete();
        d = DW'($urandom);
        tx = 8'h3C;
        cs_low();
        xfer(d, 8, m);
        cs_high();
        checks++;
        if (m !== 8'h3C) begin
            errors++;
            $display("FAIL miso_word: got %h want 3c", m);
        end
        checks++;
        if (rdy_q.size() != 1 || rdy_q[0] !== d) begin
            errors++;
            $display("FAIL miso_rx: readys=%0d want 1 word %h", rdy_q.size(), d);
        end
    endtask

    task automatic test_two_bytes();
        logic [DW-1:0] m0;
        logic [DW-1:0] m1;
        rdy_q.delete();
        busy_low = 0;
        tx = 8'h06;
        cs_low();
        xfer(8'h85, 8, m0);
        tx = 8'hC3;
        xfer(8'h5A, 8, m1);
        cs_high();
        checks++;
        if (rdy_q.size() != 2) begin
            errors++;
            $display("FAIL two_count: got %0d want 2", rdy_q.size());
        end else begin
            checks++;
            if (rdy_q[0] !== 8'h85 || rdy_q[1] !== 8'h5A) begin
                errors++;
                $display("FAIL two_rx: got %h %h want 85 5a", rdy_q[0], rdy_q[1]);
            end
        end
        checks++;
        if (m0 !== 8'h06 || m1 !== 8'hC3) begin
            errors++;
            $display("FAIL two_miso: got %h %h want 06 c3", m0, m1);
        end
        checks++;
        if (busy_low != 0) begin
            errors++;
            $display("FAIL two_busy: low_cycles=%0d want 0", busy_low);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] m;
        rdy_q.delete();
        bad_change = 0;
        cs_low();
        xfer(8'hFF, 5, m);
        cs_high();
        checks++;
        if (rdy_q.size() != 0) begin
            errors++;
            $display("FAIL abort_ready: got %0d pulses want 0", rdy_q.size());
        end
        cs_low();
        xfer(8'h12, 8, m);
        cs_high();
        checks++;
        if (rdy_q.size() != 1 || rdy_q[0] !== 8'h12) begin
            errors++;
            $display("FAIL abort_next: readys=%0d want 1 word 12", rdy_q.size());
        end
        checks++;
        if (bad_change != 0 || rx !== 8'h12) begin
            errors++;
            $display("FAIL abort_partial: silent_changes=%0d rx=%h want 0 12",
                     bad_change, rx);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] m;
        rdy_q.delete();
        cs_n = 1'b0;
        half();
        xfer(8'hE1, 4, m);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx !== '0 || busy !== 1'b0 || ready !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: rx=%h busy=%b rdy=%b miso=%b want 00 0 0 0",
                     rx, busy, ready, miso);
        end
        rst_n = 1'b1;
        xfer(8'hFF, 3, m);
        checks++;
        if (busy !== 1'b0 || rdy_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_join: busy=%b readys=%0d want 0 0",
                     busy, rdy_q.size());
        end
        cs_high();
        cs_low();
        xfer(8'h77, 8, m);
        cs_high();
        checks++;
        if (rdy_q.size() != 1 || rx !== 8'h77) begin
            errors++;
            $display("FAIL rst_mid_frame: readys=%0d rx=%h want 1 77",
                     rdy_q.size(), rx);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] m;
        logic [DW-1:0] d;
        int n_miso_bad;
        rdy_q.delete();
        busy_low = 0;
        bad_change = 0;
        n_miso_bad = 0;
        for (int f = 0; f < 12; f++) begin
            int nb;
            bit abort;
            nb = $urandom_range(1, 3);
            abort = ($urandom_range(0, 3) == 0);
            tx = DW'($urandom);
            cs_low();
            for (int b = 0; b < nb; b++) begin
                logic [DW-1:0] t;
                int bits;
                t = tx;
                d = DW'($urandom);
                bits = (abort && b == nb - 1) ? $urandom_range(1, DW - 1) : DW;
                xfer(d, bits, m);
                if (bits == DW) begin
                    exp_q.push_back(d);
                    if (m !== t) n_miso_bad++;
                end
                tx = DW'($urandom);
            end
            cs_high();
        end
        checks++;
        if (rdy_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d want %0d", rdy_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rdy_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_rx[%0d]: got %h want %h", i, rdy_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (n_miso_bad != 0) begin
            errors++;
            $display("FAIL rand_miso: %0d words wrong want 0", n_miso_bad);
        end
        checks++;
        if (busy_low != 0 || bad_change != 0) begin
            errors++;
            $display("FAIL rand_flags: busy_low=%0d silent_changes=%0d want 0 0",
                     busy_low, bad_change);
        end
    endtask

`ifdef SPI_MISO_OE_EN
    task automatic test_oe();
        checks++;
        if (miso_oe !== 1'b0) begin
            errors++;
            $display("FAIL oe_idle: got %b want 0", miso_oe);
        end
        cs_n = 1'b0;
        repeat (SS + 1) @(posedge clk);
        #1;
        checks++;
        if (miso_oe !== 1'b1) begin
            errors++;
            $display("FAIL oe_active: got %b want 1", miso_oe);
        end
        cs_n = 1'b1;
        half();
        checks++;
        if (miso_oe !== 1'b0) begin
            errors++;
            $display("FAIL oe_release: got %b want 0", miso_oe);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_miso();
        test_two_bytes();
        test_abort();
        test_reset_mid();
        test_random();
`ifdef SPI_MISO_OE_EN
        test_oe();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Physical SPI slave front-end (mode 0: CPOL=0, CPHA=0, MSB first) directly upstream of the SPI controller.
- Synchronises the external SCLK, MOSI and CS_N pins into i_clk, deserialises MOSI into words, and serialises the controller's transmit word onto MISO.
- Reports each completed word with a one-cycle ready pulse and flags an active frame with busy.
- Produces exactly the i_spi_data_rx / i_spi_ready / i_spi_busy set that the SPI controller consumes.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (8): bits per SPI word.
- SYNC_STAGES, default 2: flip-flop stages on each input pin synchroniser. Legal range 2-3.

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCLK frequency.
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_sclk  in  1  SPI clock pin, asynchronous to i_clk.
- i_cs_n  in  1  SPI chip select pin, active-low, asynchronous.
- i_mosi  in  1  SPI master-out pin, asynchronous.
- o_miso  out  1  SPI master-in pin, registered.
- i_spi_data_tx  in  DATA_WIDTH  word to transmit, supplied by the controller.
- o_spi_data_rx  out  DATA_WIDTH  last complete received word.
- o_spi_ready  out  1  one-cycle pulse when o_spi_data_rx is updated.
- o_spi_busy  out  1  high while a frame is active.

Behaviour:
- Reset values: o_spi_data_rx=0, o_spi_ready=0, o_spi_busy=0, o_miso=0, bit counter=0, state=SYNC_WAIT. Synchroniser flops reset to idle levels: sclk=0, cs_n=1, mosi=0.
- All pin logic uses synchronised copies. Edges are detected from the last two synchronised SCLK samples: rise = 01, fall = 10.
- FSM states:
  - SYNC_WAIT: entered from reset. Waits for synchronised cs_n=1, then goes to IDLE. Never joins a frame already in progress.
  - IDLE: when synchronised cs_n=0, go to SHIFT; bit counter cleared.
  - SHIFT: o_spi_busy=1. When synchronised cs_n=1, go to IDLE. Any partial word is discarded, no ready pulse, counter cleared.
- RX path:
  - On each SCLK rise in SHIFT: shift register <= {shift[DATA_WIDTH-2:0], mosi}; counter increments.
  - On the rise that completes bit DATA_WIDTH-1: next cycle, o_spi_data_rx <= the full word and o_spi_ready=1 for exactly one cycle; counter wraps to 0.
  - o_spi_data_rx holds until the next completed word.
- TX path:
  - While counter=0 and no rise pending, o_miso is registered from i_spi_data_tx[DATA_WIDTH-1] every cycle. The controller may therefore update its tx word any time before the first SCLK rise of the next word.
  - On the first rise of a word, the tx shift register captures i_spi_data_tx.
  - On each subsequent SCLK fall, the tx shift register shifts left and o_miso = its new MSB.
  - After the last bit of a word, o_miso reverts to tracking i_spi_data_tx.
- Word boundaries: multiple words per CS frame are allowed (address byte then data byte). The counter wraps with no CS toggle needed.
- Simultaneous events:
  - cs_n rising in the same cycle as a completing SCLK rise: the word completes and the ready pulse fires, then the FSM goes to IDLE.
  - An SCLK rise while in IDLE or SYNC_WAIT is ignored.
- Outside SHIFT, o_miso is driven 0 (unless SPI_MISO_OE_EN is defined).
- Latency: ready asserts 1 + SYNC_STAGES + 1 i_clk cycles after the final SCLK rising pin edge.
- Reset mid-frame: all state is cleared immediately. Operation resumes only after cs_n is seen high (SYNC_WAIT).

Optional Feature:
- Macro: SPI_MISO_OE_EN.
- Defined: adds output port o_miso_oe (1 bit, reset 0), high only in SHIFT, for an external tristate buffer. o_miso is then don't-care outside SHIFT and holds the tracked value.
- Undefined: no o_miso_oe port; o_miso forced 0 outside SHIFT.

Test Plan:
- Reset, CS low, MOSI sends 0xA5 at SCLK = i_clk/10 -> one o_spi_ready pulse, o_spi_data_rx=0xA5, o_spi_busy high throughout the frame.
- i_spi_data_tx=0x3C before CS falls, 8 SCLK cycles -> MISO sampled on rises reads 0x3C MSB first.
- One CS frame with two bytes: MOSI 0x85 then 0x5A; i_spi_data_tx changes 0x06 -> 0xC3 between bytes -> two ready pulses with rx 0x85, 0x5A; MISO returns 0x06 then 0xC3.
- CS deasserted after 5 bits of 0xFF, then a full frame of 0x12 -> no ready for the aborted word; ready with 0x12; o_spi_data_rx never shows a partial value.
- Assert i_rst_n low mid-byte, release while CS still low, clock 3 more bits, raise CS, then send a full frame of 0x77 -> no ready until the new frame; rx=0x77.
- With SPI_MISO_OE_EN defined: o_miso_oe=0 in reset/IDLE, 1 within SYNC_STAGES+1 cycles of CS falling, 0 after CS rises.
